// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM for the MIPS-subset CPU.
// It steps each instruction through IF/ID/EXE/MEM/WB. It issues a one-cycle
// pcWre pulse together with the PC source select. It also drives the IR,
// register-file, ALU-mux and data-memory enables. The FSM waits in IF and MEM
// until memory reports ready.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   opcode      in   IR[31:26]; sampled into op_q while in ID
//   zero        in   ALU zero flag, used in BR
//   mem_ready   in   memory access complete this cycle
//   pcWre       out  PC write strobe (one pulse per retired instruction)
//   pcSrc       out  00 PC+4, 01 branch target, 10 jump target
//   irWre       out  IR load enable
//   regWre      out  register file write enable
//   regDst      out  1: rd, 0: rt
//   aluSrcB     out  1: extended immediate, 0: rt
//   extSel      out  1: sign-extend, 0: zero-extend
//   wbSrc       out  1: data memory, 0: ALU result
//   memRd       out  data memory read enable
//   memWr       out  data memory write enable
//   state       out  current state encoding
//   halted      out  FSM is in HALT
//   illegal     out  sticky flag: an unknown opcode was decoded
//   insn_count  out  retired-instruction counter, wraps
module mc_ctrl_fsm #(
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcWre,
  output logic [1:0]       pcSrc,
  output logic             irWre,
  output logic             regWre,
  output logic             regDst,
  output logic             aluSrcB,
  output logic             extSel,
  output logic             wbSrc,
  output logic             memRd,
  output logic             memWr,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] insn_count
);

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_MA   = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_HALT = 3'b100;
  localparam logic [2:0] S_BR   = 3'b101;
  localparam logic [2:0] S_EXE  = 3'b110;
  localparam logic [2:0] S_WB   = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  logic [2:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_rdy;

  // When the memory never stalls, act as if mem_ready were always high.
  assign mem_rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IF:  if (mem_rdy) state_d = S_ID;
      S_ID: begin
        op_d = opcode;
        case (opcode)
          OP_R, OP_ADDI, OP_ORI: state_d = S_EXE;
          OP_LW, OP_SW:          state_d = S_MA;
          OP_BEQ:                state_d = S_BR;
          OP_J:                  state_d = S_IF;
          OP_HALT:               state_d = S_HALT;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXE: state_d = S_WB;
      S_WB:  state_d = S_IF;
      S_MA:  state_d = S_MEM;
      S_MEM: if (mem_rdy) state_d = (op_q == OP_LW) ? S_WB : S_IF;
      S_BR:  state_d = S_IF;
      default: state_d = S_HALT;
    endcase
  end

  // Output decode. The strobes are forced low while reset is held, so that an
  // aborted access never reaches the datapath. Doing this in the combinational
  // path makes the abort take effect immediately.
  always_comb begin
    pcWre   = 1'b0;
    pcSrc   = 2'b00;
    irWre   = 1'b0;
    regWre  = 1'b0;
    regDst  = 1'b0;
    aluSrcB = 1'b0;
    extSel  = 1'b0;
    wbSrc   = 1'b0;
    memRd   = 1'b0;
    memWr   = 1'b0;
    if (reset) begin
      case (state_q)
        S_IF: irWre = mem_rdy;
        // A jump retires in ID. op_q is not loaded yet, so decode the live opcode.
        S_ID: if (opcode == OP_J) begin
          pcWre = 1'b1;
          pcSrc = 2'b10;
        end
        S_EXE: begin
          aluSrcB = (op_q != OP_R);
          extSel  = (op_q == OP_ADDI);
        end
        S_WB: begin
          regWre = 1'b1;
          regDst = (op_q == OP_R);
          wbSrc  = (op_q == OP_LW);
          pcWre  = 1'b1;
        end
        S_MA: begin
          aluSrcB = 1'b1;
          extSel  = 1'b1;
        end
        S_MEM: begin
          memRd = (op_q == OP_LW);
          memWr = (op_q != OP_LW);
          pcWre = (op_q != OP_LW) && mem_rdy;
        end
        S_BR: begin
          pcWre = 1'b1;
          pcSrc = zero ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  assign cnt_d      = cnt_q + CNT_W'(pcWre);
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign insn_count = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_MA = 3'd2, S_MEM = 3'd3,
                         S_HALT = 3'd4, S_BR = 3'd5, S_EXE = 3'd6, S_WB = 3'd7;
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0d,
                         OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04,
                         OP_J = 6'h02, OP_HALT = 6'h3f, OP_BAD = 6'h15;

  logic        clk, reset, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pcWre, irWre, regWre, regDst, aluSrcB, extSel, wbSrc, memRd, memWr, halted, illegal;
  logic [1:0]  pcSrc;
  logic [2:0]  state;
  logic [31:0] insn_count;

  logic        p4_pcWre, p4_irWre, p4_regWre, p4_regDst, p4_aluSrcB, p4_extSel, p4_wbSrc;
  logic        p4_memRd, p4_memWr, p4_halted, p4_illegal;
  logic [1:0]  p4_pcSrc;
  logic [2:0]  p4_state;
  logic [3:0]  p4_insn_count;

  mc_ctrl_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcWre(pcWre), .pcSrc(pcSrc), .irWre(irWre), .regWre(regWre), .regDst(regDst),
    .aluSrcB(aluSrcB), .extSel(extSel), .wbSrc(wbSrc), .memRd(memRd), .memWr(memWr),
    .state(state), .halted(halted), .illegal(illegal), .insn_count(insn_count)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pcWre(p4_pcWre), .pcSrc(p4_pcSrc), .irWre(p4_irWre), .regWre(p4_regWre),
    .regDst(p4_regDst), .aluSrcB(p4_aluSrcB), .extSel(p4_extSel), .wbSrc(p4_wbSrc),
    .memRd(p4_memRd), .memWr(p4_memWr), .state(p4_state), .halted(p4_halted),
    .illegal(p4_illegal), .insn_count(p4_insn_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: {state, pcWre, pcSrc, irWre, regWre, regDst, aluSrcB, extSel, wbSrc, memRd, memWr, halted}
  logic [14:0] act;
  assign act = {state, pcWre, pcSrc, irWre, regWre, regDst, aluSrcB, extSel, wbSrc, memRd, memWr, halted};

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        mr;
    logic [14:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [14:0] ex(input logic [2:0] st, input logic pcw, input logic [1:0] src,
                                     input logic irw, input logic regw, input logic rdst,
                                     input logic asrc, input logic ext, input logic wbs,
                                     input logic mrd, input logic mwr);
    return {st, pcw, src, irw, regw, rdst, asrc, ext, wbs, mrd, mwr, (st == S_HALT)};
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
  endtask

  // Drive inputs at a falling edge, check just after, then advance to the next falling edge.
  task automatic step(input logic [5:0] op, input logic z, input logic mr,
                      input logic [14:0] e, input string name);
    opcode = op; zero = z; mem_ready = mr;
    #1;
    chk(name, 32'(act), 32'(e));
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
    reset = 1'b0;
    #1;
    chk({tag, "_rst_out"}, 32'(act), 32'(ex(S_IF,0,0,0,0,0,0,0,0,0,0)));
    chk({tag, "_rst_cnt"}, insn_count, 32'd0);
    chk({tag, "_rst_ill"}, 32'(illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic mr,
                     input logic [14:0] e, input string name);
    vec_t v;
    v.op = op; v.z = z; v.mr = mr; v.exp = e; v.name = name;
    tbl.push_back(v);
  endtask

  int pulses;

  initial begin
    reset = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;

    // ex(st, pcw, src, irw, regw, rdst, asrc, ext, wbs, mrd, mwr)
    add(OP_R,   0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "r_if");
    add(OP_R,   0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "r_id");
    add(OP_R,   0, 1, ex(S_EXE,0,2'b00,0,0,0,0,0,0,0,0), "r_exe");
    add(OP_R,   0, 1, ex(S_WB, 1,2'b00,0,1,1,0,0,0,0,0), "r_wb");
    add(OP_ADDI,0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "addi_if");
    add(OP_ADDI,0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "addi_id");
    add(OP_ADDI,0, 1, ex(S_EXE,0,2'b00,0,0,0,1,1,0,0,0), "addi_exe");
    add(OP_ADDI,0, 1, ex(S_WB, 1,2'b00,0,1,0,0,0,0,0,0), "addi_wb");
    add(OP_ORI, 0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "ori_if");
    add(OP_ORI, 0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "ori_id");
    add(OP_ORI, 0, 1, ex(S_EXE,0,2'b00,0,0,0,1,0,0,0,0), "ori_exe");
    add(OP_ORI, 0, 1, ex(S_WB, 1,2'b00,0,1,0,0,0,0,0,0), "ori_wb");
    add(OP_LW,  0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "lw_if");
    add(OP_LW,  0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "lw_id");
    add(OP_LW,  0, 1, ex(S_MA, 0,2'b00,0,0,0,1,1,0,0,0), "lw_ma");
    add(OP_LW,  0, 0, ex(S_MEM,0,2'b00,0,0,0,0,0,0,1,0), "lw_mem_w1");
    add(OP_LW,  0, 0, ex(S_MEM,0,2'b00,0,0,0,0,0,0,1,0), "lw_mem_w2");
    add(OP_LW,  0, 0, ex(S_MEM,0,2'b00,0,0,0,0,0,0,1,0), "lw_mem_w3");
    add(OP_LW,  0, 1, ex(S_MEM,0,2'b00,0,0,0,0,0,0,1,0), "lw_mem_done");
    add(OP_LW,  0, 1, ex(S_WB, 1,2'b00,0,1,0,0,0,1,0,0), "lw_wb");
    add(OP_SW,  0, 0, ex(S_IF, 0,2'b00,0,0,0,0,0,0,0,0), "sw_if_wait");
    add(OP_SW,  0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "sw_if");
    add(OP_SW,  0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "sw_id");
    add(OP_SW,  0, 1, ex(S_MA, 0,2'b00,0,0,0,1,1,0,0,0), "sw_ma");
    add(OP_SW,  0, 1, ex(S_MEM,1,2'b00,0,0,0,0,0,0,0,1), "sw_mem");
    add(OP_BEQ, 0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "beq1_if");
    add(OP_BEQ, 0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "beq1_id");
    add(OP_BEQ, 1, 1, ex(S_BR, 1,2'b01,0,0,0,0,0,0,0,0), "beq1_br");
    add(OP_BEQ, 0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "beq0_if");
    add(OP_BEQ, 0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "beq0_id");
    add(OP_BEQ, 0, 1, ex(S_BR, 1,2'b00,0,0,0,0,0,0,0,0), "beq0_br");
    add(OP_J,   0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "j_if");
    add(OP_J,   0, 1, ex(S_ID, 1,2'b10,0,0,0,0,0,0,0,0), "j_id");
    add(OP_R,   0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "after_j_if");

    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].op, tbl[i].z, tbl[i].mr, tbl[i].exp, tbl[i].name);
    chk("cnt_after_table", insn_count, 32'd8);
    chk("illegal_after_table", 32'(illegal), 32'd0);

    // The first R-type retires after exactly 4 cycles.
    do_reset("r4");
    for (int i = 0; i < 4; i++) begin
      opcode = OP_R; mem_ready = 1'b1;
      @(negedge clk);
    end
    chk("r_cnt_4cyc", insn_count, 32'd1);

    // A halt opcode parks the FSM without setting the illegal flag.
    do_reset("halt");
    step(OP_HALT, 0, 1, ex(S_IF,0,2'b00,1,0,0,0,0,0,0,0), "halt_if");
    step(OP_HALT, 0, 1, ex(S_ID,0,2'b00,0,0,0,0,0,0,0,0), "halt_id");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      opcode = OP_J; mem_ready = 1'b1;
      #1;
      if (pcWre) pulses++;
      @(negedge clk);
    end
    chk("halt_out", 32'(act), 32'(ex(S_HALT,0,2'b00,0,0,0,0,0,0,0,0)));
    chk("halt_nopcw", 32'(pulses), 32'd0);
    chk("halt_illegal", 32'(illegal), 32'd0);
    chk("halt_cnt", insn_count, 32'd0);

    // An unknown opcode also halts, and sets the sticky illegal flag.
    do_reset("bad");
    step(OP_BAD, 0, 1, ex(S_IF,0,2'b00,1,0,0,0,0,0,0,0), "bad_if");
    step(OP_BAD, 0, 1, ex(S_ID,0,2'b00,0,0,0,0,0,0,0,0), "bad_id");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      opcode = OP_J;
      #1;
      if (pcWre) pulses++;
      @(negedge clk);
    end
    chk("bad_out", 32'(act), 32'(ex(S_HALT,0,2'b00,0,0,0,0,0,0,0,0)));
    chk("bad_nopcw", 32'(pulses), 32'd0);
    chk("bad_illegal", 32'(illegal), 32'd1);

    // Asserting reset during the MEM stage of sw aborts the instruction immediately.
    do_reset("swrst");
    step(OP_J,  0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "swrst_j_if");
    step(OP_J,  0, 1, ex(S_ID, 1,2'b10,0,0,0,0,0,0,0,0), "swrst_j_id");
    step(OP_SW, 0, 1, ex(S_IF, 0,2'b00,1,0,0,0,0,0,0,0), "swrst_if");
    step(OP_SW, 0, 1, ex(S_ID, 0,2'b00,0,0,0,0,0,0,0,0), "swrst_id");
    step(OP_SW, 0, 1, ex(S_MA, 0,2'b00,0,0,0,1,1,0,0,0), "swrst_ma");
    chk("swrst_cnt_before", insn_count, 32'd1);
    opcode = OP_SW; mem_ready = 1'b0;
    #1;
    chk("swrst_mem", 32'(act), 32'(ex(S_MEM,0,2'b00,0,0,0,0,0,0,0,1)));
    #1;
    reset = 1'b0;
    #1;
    chk("swrst_memwr", 32'(memWr), 32'd0);
    chk("swrst_state", 32'(state), 32'(S_IF));
    chk("swrst_cnt", insn_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // The 4-bit counter wraps from 15 to 0 on the 16th jump.
    do_reset("wrap");
    for (int k = 1; k <= 16; k++) begin
      step(OP_J, 0, 1, ex(S_IF,0,2'b00,1,0,0,0,0,0,0,0), "wrap_if");
      step(OP_J, 0, 1, ex(S_ID,1,2'b10,0,0,0,0,0,0,0,0), "wrap_id");
      if (k == 15) chk("wrap_cnt15", 32'(p4_insn_count), 32'd15);
    end
    chk("wrap_cnt0", 32'(p4_insn_count), 32'd0);
    chk("wrap_cnt_wide", insn_count, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
